ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Sequences ownership of the 64K internal SRAM port between three requesters:
  - the flash boot loader, before image load completes;
  - the 8-bit CPU bus, in normal run;
  - the diagnostics SPI engine, while the CPU is halted.
- Replaces the ad-hoc halt/read_complete muxing with an explicit state machine.
- Drives CPU RDY and a halt-drain handshake, so diagnostics never collide with an in-flight CPU bus cycle.

Parameters:
- DRAIN_CYCLES, 4, consecutive idle cycles (cpu_access_active low) required before a halt is acknowledged.
- ACCESS_CYCLES, 2, SRAM cycles per diagnostic access; read data is valid on the last one.
- RESUME_CYCLES, 2, cycles RDY is held low after halt release, before returning to run.
- HALT_TIMEOUT, 1023, watchdog limit in cycles (used only with ARB_WATCHDOG_EN).

Ports:
- clk  input  1  system clock (SB_HFOSC domain)
- rst  input  1  reset, synchronous, active-high
- boot_done  input  1  flash image load complete (read_complete)
- flash_addr  input  16  boot loader address
- flash_din  input  8  boot loader write data
- flash_cs  input  1  boot loader chip select
- flash_we  input  1  boot loader write enable
- cpu_addr  input  16  CPU bus address
- cpu_din  input  8  CPU bus write data
- cpu_cs  input  1  CPU-side chip select from the decode logic
- cpu_we  input  1  CPU-side write enable
- cpu_access_active  input  1  CPU bus cycle in progress
- rdyin  input  1  external RDY from the host board
- halt_req  input  1  diagnostics requests CPU halt (level)
- halt_ack  output  1  CPU drained; diagnostics owns the SRAM
- diag_req  input  1  diagnostic single access request (level, held until diag_gnt)
- diag_addr  input  16  diagnostic address
- diag_din  input  8  diagnostic write data
- diag_we  input  1  diagnostic write (1) / read (0)
- diag_gnt  output  1  one-cycle pulse: access done, ram read data valid
- ram_addr  output  16  SRAM address
- ram_din  output  8  SRAM write data
- ram_cs  output  1  SRAM chip select
- ram_we  output  1  SRAM write enable
- rdy  output  1  CPU RDY
- timeout_flag  output  1  sticky watchdog flag (0 when feature absent)
- state_dbg  output  3  current state encoding

Behaviour:

States, with state_dbg encoding:
- BOOT=0, RUN=1, DRAIN=2, HALTED=3, DIAG_ACC=4, RESUME=5.

Reset (rst high at a clk edge):
- state=BOOT; all counters 0.
- halt_ack=0, diag_gnt=0, rdy=0, timeout_flag=0.
- rst mid-access aborts immediately: no further ram_we; a pending diag_gnt is dropped.

SRAM port mux:
- Combinational from the registered state.
- BOOT: flash_* drive the SRAM port.
- RUN, DRAIN, RESUME: cpu_* drive the SRAM port.
- HALTED: ram_cs=0, ram_we=0, ram_addr=diag_addr.
- DIAG_ACC: ram_addr=diag_addr, ram_din=diag_din, ram_cs=1; ram_we=diag_we in the first access cycle only.

Transitions:
- BOOT->RUN when boot_done=1. boot_done is treated as sticky: only rst returns to BOOT.
- RUN->DRAIN when halt_req=1.
- DRAIN:
  - idle counter increments while cpu_access_active=0 and clears to 0 when it is 1;
  - counter reaching DRAIN_CYCLES -> HALTED;
  - halt_req=0 -> RUN, counter cleared.
- HALTED:
  - diag_req=1 -> DIAG_ACC;
  - else halt_req=0 -> RESUME;
  - if both occur in the same cycle, diag_req wins.
- DIAG_ACC:
  - runs exactly ACCESS_CYCLES cycles;
  - diag_gnt=1 in the last cycle only, then -> HALTED;
  - halt_req falling mid-access is ignored until the access completes.
- RESUME: after RESUME_CYCLES cycles -> RUN; a halt_req re-asserted during RESUME is honoured on entry to RUN.

Registered outputs:
- halt_ack=1 exactly in HALTED and DIAG_ACC.
- rdy = (state==RUN) & rdyin. rdy=0 in every other state.

Counters:
- One shared counter, width clog2 of the largest parameter + 1.
- Cleared on every state change; never wraps.
- diag_gnt is never asserted outside DIAG_ACC.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined:
  - DRAIN also counts total cycles spent in DRAIN;
  - reaching HALT_TIMEOUT forces HALTED and sets timeout_flag=1;
  - timeout_flag stays set until rst.
- Undefined:
  - DRAIN waits indefinitely for the idle condition;
  - timeout_flag is tied to 0.

Test Plan:
- Boot: rst 1 cycle, boot_done=0, flash_cs=1, flash_addr=0x1234 -> ram_addr=0x1234, rdy=0, state_dbg=0. Raise boot_done -> next cycle state_dbg=1, rdy=rdyin.
- Drain: in RUN, assert halt_req with cpu_access_active toggling 1,0,0,1,0,0,0,0 -> rdy=0 from the next cycle; halt_ack rises only after the 4th consecutive idle cycle.
- Diag write then read: in HALTED, diag_req, diag_we=1, diag_addr=0x8000, diag_din=0xA5 -> ram_we=1 for 1 cycle, diag_gnt pulse at cycle 2. Read back the same address -> ram_we=0, ram_cs=1 for 2 cycles, SRAM output 0xA5 at diag_gnt.
- Simultaneous events: in HALTED, drop halt_req and raise diag_req in the same cycle -> DIAG_ACC first, then RESUME; rdy returns 1 RESUME_CYCLES (2) cycles after leaving HALTED.
- Reset mid-access: rst asserted in the first DIAG_ACC cycle -> next cycle state_dbg=0, ram_we=0, halt_ack=0, no diag_gnt.
- Watchdog (ARB_WATCHDOG_EN, HALT_TIMEOUT=16): halt_req with cpu_access_active held 1 -> at cycle 16 state_dbg=3, timeout_flag=1, halt_ack=1. Without the macro, the block stays in DRAIN indefinitely and timeout_flag=0.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// SRAM port arbiter: boot loader, CPU bus and diagnostics with halt-drain handshake.
// Define ARB_WATCHDOG_EN to add a DRAIN timeout that forces HALTED and sets timeout_flag.
module ram_access_arbiter #(
    parameter int DRAIN_CYCLES  = 4,
    parameter int ACCESS_CYCLES = 2,
    parameter int RESUME_CYCLES = 2,
    parameter int HALT_TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_done,
    input  logic [15:0] flash_addr,
    input  logic [7:0]  flash_din,
    input  logic        flash_cs,
    input  logic        flash_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic        cpu_access_active,
    input  logic        rdyin,
    input  logic        halt_req,
    output logic        halt_ack,
    input  logic        diag_req,
    input  logic [15:0] diag_addr,
    input  logic [7:0]  diag_din,
    input  logic        diag_we,
    output logic        diag_gnt,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        rdy,
    output logic        timeout_flag,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        RUN      = 3'd1,
        DRAIN    = 3'd2,
        HALTED   = 3'd3,
        DIAG_ACC = 3'd4,
        RESUME   = 3'd5
    } state_t;

    localparam int M1 = (DRAIN_CYCLES > ACCESS_CYCLES) ? DRAIN_CYCLES : ACCESS_CYCLES;
    localparam int M2 = (M1 > RESUME_CYCLES) ? M1 : RESUME_CYCLES;
    localparam int M3 = (M2 > HALT_TIMEOUT) ? M2 : HALT_TIMEOUT;
    localparam int CW = $clog2(M3 + 1);

    localparam logic [CW-1:0] DRAIN_MAX  = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] ACC_LAST   = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] RES_LAST   = CW'(RESUME_CYCLES - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

`ifdef ARB_WATCHDOG_EN
    localparam logic [CW-1:0] HALT_MAX = CW'(HALT_TIMEOUT);
    logic [CW-1:0] wd_cnt, wd_nx, wd_inc;
    logic          tflag, tflag_nx;

    assign wd_inc = (wd_cnt == '1) ? wd_cnt : wd_cnt + CW'(1);
    assign timeout_flag = tflag;
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            BOOT: begin
                if (boot_done) state_nx = RUN;
            end
            RUN: begin
                if (halt_req) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!halt_req)
                    state_nx = RUN;
                else if (cpu_access_active)
                    cnt_nx = '0;
                else if (cnt_inc == DRAIN_MAX)
                    state_nx = HALTED;
                else
                    cnt_nx = cnt_inc;
            end
            HALTED: begin
                if (diag_req)
                    state_nx = DIAG_ACC;
                else if (!halt_req)
                    state_nx = RESUME;
            end
            DIAG_ACC: begin
                if (cnt == ACC_LAST) state_nx = HALTED;
                else cnt_nx = cnt_inc;
            end
            RESUME: begin
                if (cnt == RES_LAST) state_nx = RUN;
                else cnt_nx = cnt_inc;
            end
            default: state_nx = BOOT;
        endcase

`ifdef ARB_WATCHDOG_EN
        tflag_nx = tflag;
        wd_nx    = (state == DRAIN) ? wd_inc : '0;
        if (state == DRAIN && halt_req && wd_inc == HALT_MAX) begin
            state_nx = HALTED;
            tflag_nx = 1'b1;
        end
        if (state_nx != state) wd_nx = '0;
`endif

        if (state_nx != state) cnt_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            cnt      <= '0;
            halt_ack <= 1'b0;
            diag_gnt <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            halt_ack <= (state_nx == HALTED) || (state_nx == DIAG_ACC);
            diag_gnt <= (state_nx == DIAG_ACC) && (cnt_nx == ACC_LAST);
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            tflag  <= 1'b0;
        end else begin
            wd_cnt <= wd_nx;
            tflag  <= tflag_nx;
        end
    end
`endif

    assign rdy       = (state == RUN) & rdyin;
    assign state_dbg = state;

    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_cs   = cpu_cs;
        ram_we   = cpu_we;
        case (state)
            BOOT: begin
                ram_addr = flash_addr;
                ram_din  = flash_din;
                ram_cs   = flash_cs;
                ram_we   = flash_we;
            end
            HALTED: begin
                ram_addr = diag_addr;
                ram_din  = diag_din;
                ram_cs   = 1'b0;
                ram_we   = 1'b0;
            end
            DIAG_ACC: begin
                ram_addr = diag_addr;
                ram_din  = diag_din;
                ram_cs   = 1'b1;
                ram_we   = diag_we && (cnt == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed self-checking bench for ram_access_arbiter with a behavioural SRAM.
// Watchdog expectations follow ARB_WATCHDOG_EN when the bench is built with it.
module tb_ram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_done;
    logic [15:0] flash_addr;
    logic [7:0]  flash_din;
    logic        flash_cs, flash_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_cs, cpu_we, cpu_access_active;
    logic        rdyin, halt_req, halt_ack;
    logic        diag_req;
    logic [15:0] diag_addr;
    logic [7:0]  diag_din;
    logic        diag_we, diag_gnt;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_cs, ram_we, rdy, timeout_flag;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] ram_dout;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    ram_access_arbiter #(
        .DRAIN_CYCLES(4), .ACCESS_CYCLES(2),
        .RESUME_CYCLES(2), .HALT_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .boot_done(boot_done),
        .flash_addr(flash_addr), .flash_din(flash_din),
        .flash_cs(flash_cs), .flash_we(flash_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .cpu_access_active(cpu_access_active), .rdyin(rdyin),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .diag_req(diag_req), .diag_addr(diag_addr),
        .diag_din(diag_din), .diag_we(diag_we), .diag_gnt(diag_gnt),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_cs(ram_cs), .ram_we(ram_we), .rdy(rdy),
        .timeout_flag(timeout_flag), .state_dbg(state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; boot_done = 1'b0;
        flash_cs = 1'b1; flash_we = 1'b0;
        flash_addr = 16'h1234; flash_din = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        n_tests++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state_dbg); end
        n_tests++; if (ram_addr !== 16'h1234) begin n_fail++; $display("FAIL rst_flash_addr got %h want 1234", ram_addr); end
        n_tests++; if (ram_cs !== 1'b1) begin n_fail++; $display("FAIL rst_flash_cs got %b want 1", ram_cs); end
        n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy got %b want 0", rdy); end
        n_tests++; if (halt_ack !== 1'b0 || diag_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_ack_gnt got %b%b want 00", halt_ack, diag_gnt); end
        n_tests++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b want 0", timeout_flag); end
    endtask

    task automatic test_boot();
        boot_done = 1'b1;
        tick();
        n_tests++; if (state_dbg !== 3'd1) begin n_fail++; $display("FAIL boot_run got %0d want 1", state_dbg); end
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL boot_rdy got %b want 1", rdy); end
        rdyin = 1'b0; #1;
        n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL boot_rdyin_low got %b want 0", rdy); end
        rdyin = 1'b1;
        n_tests++; if (ram_addr !== 16'h4321 || ram_cs !== 1'b1) begin n_fail++; $display("FAIL run_cpu_mux got %h/%b want 4321/1", ram_addr, ram_cs); end
        boot_done = 1'b0;
        tick();
        n_tests++; if (state_dbg !== 3'd1) begin n_fail++; $display("FAIL boot_sticky got %0d want 1", state_dbg); end
    endtask

    task automatic test_drain();
        logic [7:0] pat;
        pat = 8'b0000_1001;
        halt_req = 1'b1;
        cpu_access_active = 1'b1;
        tick();
        n_tests++; if (state_dbg !== 3'd2 || rdy !== 1'b0) begin n_fail++; $display("FAIL drain_enter got %0d/%b want 2/0", state_dbg, rdy); end
        for (int i = 0; i < 8; i++) begin
            cpu_access_active = pat[i];
            tick();
            n_tests++; if (halt_ack !== (i == 7)) begin n_fail++; $display("FAIL drain_ack_%0d got %b want %b", i, halt_ack, (i == 7)); end
            n_tests++; if (state_dbg !== ((i == 7) ? 3'd3 : 3'd2)) begin n_fail++; $display("FAIL drain_state_%0d got %0d want %0d", i, state_dbg, (i == 7) ? 3 : 2); end
        end
    endtask

    task automatic test_diag_write();
        diag_addr = 16'h8000; diag_din = 8'hA5; diag_we = 1'b1;
        #1;
        n_tests++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 16'h8000) begin n_fail++; $display("FAIL halted_port got %b%b/%h want 00/8000", ram_cs, ram_we, ram_addr); end
        diag_req = 1'b1;
        tick();
        n_tests++; if (state_dbg !== 3'd4 || ram_we !== 1'b1 || ram_cs !== 1'b1) begin n_fail++; $display("FAIL wr_cyc1 got %0d/%b%b want 4/11", state_dbg, ram_cs, ram_we); end
        n_tests++; if (diag_gnt !== 1'b0 || ram_din !== 8'hA5) begin n_fail++; $display("FAIL wr_cyc1_gnt got %b/%h want 0/a5", diag_gnt, ram_din); end
        tick();
        n_tests++; if (ram_we !== 1'b0 || diag_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_cyc2 got we=%b gnt=%b want 0/1", ram_we, diag_gnt); end
        diag_req = 1'b0;
        tick();
        n_tests++; if (state_dbg !== 3'd3 || diag_gnt !== 1'b0 || halt_ack !== 1'b1) begin n_fail++; $display("FAIL wr_done got %0d/%b/%b want 3/0/1", state_dbg, diag_gnt, halt_ack); end
    endtask

    task automatic test_diag_read();
        diag_we = 1'b0; diag_req = 1'b1;
        tick();
        n_tests++; if (ram_cs !== 1'b1 || ram_we !== 1'b0 || diag_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_cyc1 got %b%b%b want 100", ram_cs, ram_we, diag_gnt); end
        tick();
        n_tests++; if (ram_cs !== 1'b1 || ram_we !== 1'b0 || diag_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_cyc2 got %b%b%b want 101", ram_cs, ram_we, diag_gnt); end
        n_tests++; if (ram_dout !== 8'hA5) begin n_fail++; $display("FAIL rd_data got %h want a5", ram_dout); end
        diag_req = 1'b0;
        tick();
        n_tests++; if (state_dbg !== 3'd3) begin n_fail++; $display("FAIL rd_done got %0d want 3", state_dbg); end
    endtask

    task automatic test_simultaneous();
        halt_req = 1'b0; diag_req = 1'b1;
        tick();
        n_tests++; if (state_dbg !== 3'd4) begin n_fail++; $display("FAIL sim_diag_first got %0d want 4", state_dbg); end
        tick();
        n_tests++; if (state_dbg !== 3'd4 || diag_gnt !== 1'b1 || halt_ack !== 1'b1) begin n_fail++; $display("FAIL sim_ignore_drop got %0d/%b/%b want 4/1/1", state_dbg, diag_gnt, halt_ack); end
        diag_req = 1'b0;
        tick();
        n_tests++; if (state_dbg !== 3'd3) begin n_fail++; $display("FAIL sim_back_halted got %0d want 3", state_dbg); end
        tick();
        n_tests++; if (state_dbg !== 3'd5 || rdy !== 1'b0 || halt_ack !== 1'b0) begin n_fail++; $display("FAIL sim_resume1 got %0d/%b/%b want 5/0/0", state_dbg, rdy, halt_ack); end
        tick();
        n_tests++; if (state_dbg !== 3'd5 || rdy !== 1'b0) begin n_fail++; $display("FAIL sim_resume2 got %0d/%b want 5/0", state_dbg, rdy); end
        tick();
        n_tests++; if (state_dbg !== 3'd1 || rdy !== 1'b1) begin n_fail++; $display("FAIL sim_run got %0d/%b want 1/1", state_dbg, rdy); end
    endtask

    task automatic test_reset_mid_access();
        int budget;
        halt_req = 1'b1; cpu_access_active = 1'b0;
        budget = 0;
        tick();
        while (state_dbg !== 3'd3 && budget < 10) begin
            tick();
            budget++;
        end
        n_tests++; if (budget != 4) begin n_fail++; $display("FAIL mid_drain_len got %0d want 4", budget); end
        diag_addr = 16'h0010; diag_din = 8'h5A; diag_we = 1'b1; diag_req = 1'b1;
        tick();
        n_tests++; if (state_dbg !== 3'd4 || ram_we !== 1'b1) begin n_fail++; $display("FAIL mid_cyc1 got %0d/%b want 4/1", state_dbg, ram_we); end
        rst = 1'b1;
        tick();
        n_tests++; if (state_dbg !== 3'd0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst got %0d/%b want 0/0", state_dbg, ram_we); end
        n_tests++; if (halt_ack !== 1'b0 || diag_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hs got %b%b want 00", halt_ack, diag_gnt); end
        rst = 1'b0; diag_req = 1'b0; halt_req = 1'b0; diag_we = 1'b0;
        tick();
        n_tests++; if (diag_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_no_gnt got %b want 0", diag_gnt); end
    endtask

    task automatic test_watchdog();
        boot_done = 1'b1;
        tick();
        n_tests++; if (state_dbg !== 3'd1) begin n_fail++; $display("FAIL wd_run got %0d want 1", state_dbg); end
        halt_req = 1'b1; cpu_access_active = 1'b1;
        tick();
`ifdef ARB_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick();
        n_tests++; if (state_dbg !== 3'd2 || timeout_flag !== 1'b0) begin n_fail++; $display("FAIL wd_pre got %0d/%b want 2/0", state_dbg, timeout_flag); end
        tick();
        n_tests++; if (state_dbg !== 3'd3 || timeout_flag !== 1'b1 || halt_ack !== 1'b1) begin n_fail++; $display("FAIL wd_fire got %0d/%b/%b want 3/1/1", state_dbg, timeout_flag, halt_ack); end
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (state_dbg !== 3'd1 || timeout_flag !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %0d/%b want 1/1", state_dbg, timeout_flag); end
`else
        for (int i = 0; i < 40; i++) tick();
        n_tests++; if (state_dbg !== 3'd2 || timeout_flag !== 1'b0 || halt_ack !== 1'b0) begin n_fail++; $display("FAIL wd_absent got %0d/%b/%b want 2/0/0", state_dbg, timeout_flag, halt_ack); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; boot_done = 1'b0;
        flash_addr = '0; flash_din = '0; flash_cs = 1'b0; flash_we = 1'b0;
        cpu_addr = 16'h4321; cpu_din = 8'h3C; cpu_cs = 1'b1; cpu_we = 1'b0;
        cpu_access_active = 1'b0; rdyin = 1'b1; halt_req = 1'b0;
        diag_req = 1'b0; diag_addr = '0; diag_din = '0; diag_we = 1'b0;
        #2;
        test_reset();
        test_boot();
        test_drain();
        test_diag_write();
        test_diag_read();
        test_simultaneous();
        test_reset_mid_access();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
